cls_vote_unit: RTL and testbench
================================

// Module: cls_vote_unit
// PURPOSE
//  N-way lockstep comparator/voter for redundant minion cores (core 0 = master).
//  Samples each core's instruction/data request bundle every cycle and forms a
//  bitwise majority-voted bundle. It flags and identifies disagreeing cores,
//  counts fault events and runs an OK/DEGRADED/FATAL health FSM.
//  Sits between the replicated cores and the shared memory fabric.
// PARAMETERS
//  NUM_CORES   3   replicated cores; odd, >= 3
//  AW          32  instruction/data address width
//  DW          32  write-data width (byte enables = DW/8)
//  CNT_W       8   fault event counter width (saturating)
//  FATAL_THR   4   fault events that force FATAL; 1..2^CNT_W-1
// PORTS
//  clk          in   1              core clock
//  rst          in   1              async reset, active-low
//  clear        in   1              sync: return FSM to OK, zero counter and masks
//  instr_req    in   N              per-core instruction request
//  instr_addr   in   N*AW           per-core instr address, core i at [i*AW +: AW]
//  data_req     in   N              per-core data request
//  data_we      in   N              per-core write enable
//  data_be      in   N*DW/8         per-core byte enables
//  data_addr    in   N*AW           per-core data address
//  data_wdata   in   N*DW           per-core write data
//  core_busy    in   N              per-core busy
//  fault        out  1              one-cycle pulse: mismatch seen last cycle
//  valid        out  1              last cycle had a request with a strict majority
//  dis_mask     out  N              cores that disagreed last cycle
//  excl_mask    out  N              sticky: cores that have ever disagreed
//  fault_cnt    out  CNT_W          saturating count of fault events
//  state        out  2              0 OK, 1 DEGRADED, 2 FATAL
//  v_instr_addr out  AW             voted instr addr, registered
//  v_data_addr  out  AW             voted data addr, registered
//  v_data_wdata out  DW             voted write data, registered
// BEHAVIOUR
//  - Reset: all outputs 0; state = OK.
//  - Per-core bundle B_i = {instr_req, instr_req ? instr_addr : 0, data_req,
//    data_req ? {data_we, data_be, data_addr} : 0, (data_req & data_we) ? wdata : 0}.
//    core_busy is included in B_i.
//  - Compare cycle: any instr_req or data_req bit is set. All other cycles are
//    idle: fault = 0, valid = 0, dis_mask = 0.
//  - Vote: each bit of V is 1 iff more than NUM_CORES/2 cores drive 1. All
//    cores vote, including excluded ones.
//  - Core i disagrees iff B_i != V. dis_mask = disagree vector, registered.
//  - No-majority event: popcount(dis_mask_next) > NUM_CORES/2. Such a cycle
//    has valid = 0. Any other compare cycle has valid = 1.
//  - Fault event: compare cycle with any disagreement. On a fault event:
//    fault = 1, fault_cnt += 1 (saturates at all-ones), excl_mask |= disagree.
//  - Latency: all outputs update on the edge after the sampled cycle (1 cycle).
//  - FSM (evaluated from next-state values):
//    OK -> DEGRADED: fault event, no majority loss, fault_cnt_next < FATAL_THR.
//    OK or DEGRADED -> FATAL: no-majority event, or fault_cnt_next >= FATAL_THR,
//      or popcount(excl_mask_next) > NUM_CORES/2.
//    DEGRADED stays DEGRADED on further minority faults below the threshold.
//    FATAL is sticky. Only clear or rst leaves FATAL.
//  - clear: takes priority over the same-cycle compare. Next state: OK,
//    fault_cnt = 0, excl_mask = 0, fault = 0. Voted outputs update normally.
//  - Voted outputs carry V fields from the last compare cycle and hold during
//    idle cycles.
//  - Reset mid-operation: everything returns to reset values immediately.
// TESTING
//  1. N=3, all cores instr_req=1, addr 0x100 -> next cycle valid=1, fault=0,
//     v_instr_addr=0x100, state=OK.
//  2. Core2 data write wdata 0xDEAD vs 0xBEEF on cores 0/1 -> fault=1,
//     dis_mask=3'b100, v_data_wdata=0xBEEF, state=DEGRADED, fault_cnt=1.
//  3. Three cores with three different instr addrs, majority failing on bits ->
//     dis_mask has >=2 bits set, valid=0, state=FATAL. Idle cycles keep FATAL.
//  4. FATAL_THR=4, core1 injects 4 single-core faults -> fault_cnt 1..4,
//     DEGRADED after the 1st, FATAL after the 4th. Then clear=1 -> OK, cnt=0.
//  5. Idle cycles with differing addr but req=0 (masked) -> fault stays 0.
//     instr_req mismatch (1,1,0) -> dis_mask=3'b100.
//  6. N=5, CNT_W=2: cores 3,4 faulty on separate events -> excl_mask=5'b11000,
//     DEGRADED. Core 2 also faults -> FATAL. 5 extra events -> fault_cnt saturates
//     at 3. rst low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cls_vote_if.sv
// cls_vote_if: replicated-core request bundles in, voted bundle and health status out
interface cls_vote_if #(
    parameter int NUM_CORES = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CNT_W = 8
);
    logic [NUM_CORES-1:0]          instr_req;
    logic [NUM_CORES*AW-1:0]       instr_addr;
    logic [NUM_CORES-1:0]          data_req;
    logic [NUM_CORES-1:0]          data_we;
    logic [NUM_CORES*(DW/8)-1:0]   data_be;
    logic [NUM_CORES*AW-1:0]       data_addr;
    logic [NUM_CORES*DW-1:0]       data_wdata;
    logic [NUM_CORES-1:0]          core_busy;
    logic                          fault;
    logic                          valid;
    logic [NUM_CORES-1:0]          dis_mask;
    logic [NUM_CORES-1:0]          excl_mask;
    logic [CNT_W-1:0]              fault_cnt;
    logic [1:0]                    state;
    logic [AW-1:0]                 v_instr_addr;
    logic [AW-1:0]                 v_data_addr;
    logic [DW-1:0]                 v_data_wdata;
    modport master (
        output instr_req, instr_addr, data_req, data_we, data_be, data_addr, data_wdata, core_busy,
        input  fault, valid, dis_mask, excl_mask, fault_cnt, state, v_instr_addr, v_data_addr, v_data_wdata
    );
    modport slave (
        input  instr_req, instr_addr, data_req, data_we, data_be, data_addr, data_wdata, core_busy,
        output fault, valid, dis_mask, excl_mask, fault_cnt, state, v_instr_addr, v_data_addr, v_data_wdata
    );
endinterface

// File: rtl/cls_vote_unit.sv
// cls_vote_unit: bitwise majority voter for lockstep cores with fault tracking and health FSM
module cls_vote_unit #(
    parameter int NUM_CORES = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CNT_W = 8,
    parameter int FATAL_THR = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    cls_vote_if.slave  bus
);
    localparam int BEW  = DW / 8;
    localparam int BW   = 4 + 2 * AW + BEW + DW;
    localparam int O_DA = DW;
    localparam int O_IA = DW + AW + BEW + 2;
    localparam int HALF = NUM_CORES / 2;
    localparam logic [CNT_W-1:0] THR = CNT_W'(FATAL_THR);
    typedef enum logic [1:0] {OK = 2'd0, DEGRADED = 2'd1, FATAL = 2'd2} state_t;
    state_t st, st_n;
    logic [BW-1:0] b [NUM_CORES];
    logic [BW-1:0] v;
    logic [NUM_CORES-1:0] dis, dis_n, dis_q, excl, excl_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic cmp, fevt, nomaj, fault_q, valid_q;
    logic [AW-1:0] iaddr_q, daddr_q;
    logic [DW-1:0] wdata_q;
    genvar i, j, k;
    // Fields of an idle request channel are masked to zero so stale buses never vote
    for (i = 0; i < NUM_CORES; i++) begin : g_core
        assign b[i] = {bus.core_busy[i], bus.instr_req[i],
                       bus.instr_req[i] ? bus.instr_addr[i*AW +: AW] : {AW{1'b0}},
                       bus.data_req[i],
                       bus.data_req[i] ? {bus.data_we[i], bus.data_be[i*BEW +: BEW], bus.data_addr[i*AW +: AW]}
                                       : {(1 + BEW + AW){1'b0}},
                       (bus.data_req[i] & bus.data_we[i]) ? bus.data_wdata[i*DW +: DW] : {DW{1'b0}}};
        assign dis[i] = b[i] != v;
    end
    for (k = 0; k < BW; k++) begin : g_bit
        logic [NUM_CORES-1:0] col;
        for (j = 0; j < NUM_CORES; j++) begin : g_col
            assign col[j] = b[j][k];
        end
        assign v[k] = $countones(col) > HALF;
    end
    assign cmp    = (|bus.instr_req) | (|bus.data_req);
    assign dis_n  = cmp ? dis : '0;
    assign fevt   = |dis_n;
    assign nomaj  = $countones(dis_n) > HALF;
    assign cnt_n  = (fevt && cnt != '1) ? cnt + 1'b1 : cnt;
    assign excl_n = excl | dis_n;
    always_comb begin
        st_n = clear ? OK
             : (st == FATAL || nomaj || cnt_n >= THR || $countones(excl_n) > HALF) ? FATAL
             : (fevt || st == DEGRADED) ? DEGRADED : OK;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st <= OK;
        else st <= st_n;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
            valid_q <= 1'b0;
            dis_q   <= '0;
            excl    <= '0;
            cnt     <= '0;
            iaddr_q <= '0;
            daddr_q <= '0;
            wdata_q <= '0;
        end else begin
            fault_q <= !clear && fevt;
            valid_q <= cmp && !nomaj;
            dis_q   <= clear ? '0 : dis_n;
            excl    <= clear ? '0 : excl_n;
            cnt     <= clear ? '0 : cnt_n;
            if (cmp) begin
                iaddr_q <= v[O_IA +: AW];
                daddr_q <= v[O_DA +: AW];
                wdata_q <= v[0 +: DW];
            end
        end
    end
    assign bus.fault        = fault_q;
    assign bus.valid        = valid_q;
    assign bus.dis_mask     = dis_q;
    assign bus.excl_mask    = excl;
    assign bus.fault_cnt    = cnt;
    assign bus.state        = st;
    assign bus.v_instr_addr = iaddr_q;
    assign bus.v_data_addr  = daddr_q;
    assign bus.v_data_wdata = wdata_q;
endmodule

// File: tb/tb_cls_vote_unit.sv
// tb_cls_vote_unit: directed vectors on a 3-core and a 5-core (CNT_W=2) voter
module tb_cls_vote_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    cls_vote_if #(.NUM_CORES(3)) i3 ();
    cls_vote_if #(.NUM_CORES(5), .CNT_W(2)) i5 ();

    cls_vote_unit #(.NUM_CORES(3), .FATAL_THR(4)) u3 (.clk(clk), .rst(rst), .clear(clear), .bus(i3));
    cls_vote_unit #(.NUM_CORES(5), .CNT_W(2), .FATAL_THR(3)) u5 (.clk(clk), .rst(rst), .clear(clear), .bus(i5));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i3.instr_req = '0; i3.instr_addr = '0; i3.data_req = '0; i3.data_we = '0;
        i3.data_be = '0; i3.data_addr = '0; i3.data_wdata = '0; i3.core_busy = '0;
        i5.instr_req = '0; i5.instr_addr = '0; i5.data_req = '0; i5.data_we = '0;
        i5.data_be = '0; i5.data_addr = '0; i5.data_wdata = '0; i5.core_busy = '0;
    endtask

    task automatic ia3(input logic [2:0] req, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        i3.instr_req = req;
        i3.instr_addr = {a2, a1, a0};
    endtask

    task automatic set5(input logic [4:0] bad);
        i5.instr_req = '1;
        for (int n = 0; n < 5; n++) i5.instr_addr[n*32 +: 32] = bad[n] ? 32'h9 : 32'h8;
    endtask

    initial begin
        idle();
        repeat (2) step();
        chk("rst_state", i3.state, 0);
        chk("rst_valid", i3.valid, 0);
        chk("rst_fault", i3.fault, 0);
        chk("rst_cnt", i3.fault_cnt, 0);
        @(negedge clk) rst = 1'b1;

        ia3(3'b111, 32'h100, 32'h100, 32'h100);
        step();
        chk("t1_valid", i3.valid, 1);
        chk("t1_fault", i3.fault, 0);
        chk("t1_iaddr", i3.v_instr_addr, 32'h100);
        chk("t1_state", i3.state, 0);

        idle();
        i3.data_req = 3'b111; i3.data_we = 3'b111; i3.data_be = 12'hFFF;
        i3.data_addr = {3{32'h200}};
        i3.data_wdata = {32'hDEAD, 32'hBEEF, 32'hBEEF};
        step();
        chk("t2_fault", i3.fault, 1);
        chk("t2_dis", i3.dis_mask, 3'b100);
        chk("t2_wdata", i3.v_data_wdata, 32'hBEEF);
        chk("t2_daddr", i3.v_data_addr, 32'h200);
        chk("t2_state", i3.state, 1);
        chk("t2_cnt", i3.fault_cnt, 1);
        chk("t2_excl", i3.excl_mask, 3'b100);

        idle();
        i3.instr_addr = {32'h1, 32'h2, 32'h3};
        i3.data_addr = {32'h4, 32'h5, 32'h6};
        step();
        chk("t5_idle_fault", i3.fault, 0);
        chk("t5_idle_valid", i3.valid, 0);
        chk("t5_idle_dis", i3.dis_mask, 0);
        chk("t5_hold_wdata", i3.v_data_wdata, 32'hBEEF);
        chk("t5_idle_cnt", i3.fault_cnt, 1);

        ia3(3'b011, 32'h40, 32'h40, 32'h40);
        step();
        chk("t5_req_dis", i3.dis_mask, 3'b100);
        chk("t5_req_cnt", i3.fault_cnt, 2);
        chk("t5_req_state", i3.state, 1);

        ia3(3'b111, 32'h1, 32'h2, 32'h4);
        step();
        chk("t3_dis", i3.dis_mask, 3'b111);
        chk("t3_valid", i3.valid, 0);
        chk("t3_state", i3.state, 2);
        chk("t3_cnt", i3.fault_cnt, 3);
        idle();
        repeat (2) step();
        chk("t3_idle_state", i3.state, 2);
        ia3(3'b111, 32'h5, 32'h5, 32'h5);
        step();
        chk("t3_clean_state", i3.state, 2);
        chk("t3_clean_valid", i3.valid, 1);

        idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_state", i3.state, 0);
        chk("clr_cnt", i3.fault_cnt, 0);
        chk("clr_excl", i3.excl_mask, 0);

        for (int n = 1; n <= 4; n++) begin
            ia3(3'b111, 32'h10, 32'h11, 32'h10);
            step();
            chk($sformatf("t4_cnt%0d", n), i3.fault_cnt, n);
            chk($sformatf("t4_state%0d", n), i3.state, n < 4 ? 1 : 2);
            chk($sformatf("t4_dis%0d", n), i3.dis_mask, 3'b010);
        end
        ia3(3'b111, 32'h20, 32'h20, 32'h21);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_clr_state", i3.state, 0);
        chk("t4_clr_cnt", i3.fault_cnt, 0);
        chk("t4_clr_fault", i3.fault, 0);
        chk("t4_clr_excl", i3.excl_mask, 0);
        chk("t4_clr_iaddr", i3.v_instr_addr, 32'h20);

        idle();
        set5(5'b01000);
        step();
        chk("t6_e1_dis", i5.dis_mask, 5'b01000);
        chk("t6_e1_state", i5.state, 1);
        set5(5'b10000);
        step();
        chk("t6_e2_excl", i5.excl_mask, 5'b11000);
        chk("t6_e2_state", i5.state, 1);
        chk("t6_e2_cnt", i5.fault_cnt, 2);
        set5(5'b00100);
        step();
        chk("t6_e3_excl", i5.excl_mask, 5'b11100);
        chk("t6_e3_state", i5.state, 2);
        chk("t6_e3_valid", i5.valid, 1);
        repeat (5) step();
        chk("t6_sat_cnt", i5.fault_cnt, 3);
        chk("t6_sat_iaddr", i5.v_instr_addr, 32'h8);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t6_rst_state", i5.state, 0);
        chk("t6_rst_cnt", i5.fault_cnt, 0);
        chk("t6_rst_excl", i5.excl_mask, 0);
        chk("t6_rst_fault", i5.fault, 0);
        chk("t6_rst_valid", i5.valid, 0);
        chk("t6_rst_dis", i5.dis_mask, 0);
        chk("t6_rst_iaddr", i5.v_instr_addr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
